// File: rtl/btb_pkg.sv
// Shared widths, entry layout and FSM state type for the branch target buffer.
package btb_pkg;
  localparam int IDX_W = 13;
  localparam int TAG_W = 8;
  localparam int TGT_W = 32;
  localparam int DEPTH = 1 << IDX_W;

  typedef struct packed {
    logic             V;
    logic [TAG_W-1:0] BIA;
    logic [TGT_W-1:0] BTA;
  } btb_entry_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } btb_state_t;
endpackage

// File: rtl/btb_store_if.sv
// Request/response bundle between the predictor/update paths and the BTB storage.
interface btb_store_if;
  import btb_pkg::*;

  // No backpressure: wen/ren are accepted on the edge they are high, but
  // wen is dropped while ready=0 or flush=1; rvalid pulses one cycle after ren.
  logic             flush;
  logic             ready;
  logic             wen;
  logic [IDX_W-1:0] waddr;
  logic             wV;
  logic [TAG_W-1:0] wBIA;
  logic [TGT_W-1:0] wBTA;
  logic             ren;
  logic [IDX_W-1:0] raddr;
  logic [TAG_W-1:0] rtag;
  logic             rvalid;
  logic             V;
  logic [TAG_W-1:0] BIA;
  logic [TGT_W-1:0] BTA;
  logic             hit;

  modport master (
    output flush, wen, waddr, wV, wBIA, wBTA, ren, raddr, rtag,
    input  ready, rvalid, V, BIA, BTA, hit
  );

  modport slave (
    input  flush, wen, waddr, wV, wBIA, wBTA, ren, raddr, rtag,
    output ready, rvalid, V, BIA, BTA, hit
  );
endinterface

// File: rtl/btb_ram.sv
// 1R1W synchronous tag/target array, registered read, no reset (SRAM-macro shaped).
module btb_ram #(
  parameter int AW = 13,
  parameter int DW = 40
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/btb_store.sv
// BTB storage: invalidate sweep FSM, valid flops, write-first bypass and
// registered read outputs with combinational tag compare.
module btb_store
  import btb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  btb_store_if.slave  bus,
  output btb_state_t  dbg_state
);
  localparam logic [IDX_W:0] LAST_IDX = (IDX_W+1)'(DEPTH - 1);

  btb_state_t             state;
  logic [IDX_W:0]         clr_idx;
  logic [DEPTH-1:0]       valid;
  logic                   wr_en;
  logic                   byp;
  logic                   rvalid_q;
  logic                   zero_q;
  logic                   byp_q;
  logic                   v_q;
  logic [TAG_W-1:0]       rtag_q;
  btb_entry_t             byp_ent;
  logic [TAG_W+TGT_W-1:0] ram_rd;
  logic                   v_o;
  logic [TAG_W-1:0]       bia_o;
  logic [TGT_W-1:0]       bta_o;

  assign wr_en = bus.wen && (state == RUN) && !bus.flush;
  assign byp   = wr_en && (bus.waddr == bus.raddr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= INIT;
      clr_idx <= '0;
    end else if (bus.flush) begin
      state   <= INIT;
      clr_idx <= '0;
    end else if (state == INIT) begin
      // Counter parks on the last index rather than wrapping.
      if (clr_idx == LAST_IDX) state <= RUN;
      else clr_idx <= clr_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == INIT) valid[clr_idx[IDX_W-1:0]] <= 1'b0;
    else if (wr_en) valid[bus.waddr] <= bus.wV;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_q <= 1'b0;
      zero_q   <= 1'b1;
      byp_q    <= 1'b0;
      v_q      <= 1'b0;
      rtag_q   <= '0;
      byp_ent  <= '0;
    end else begin
      rvalid_q <= bus.ren;
      if (bus.ren) begin
        // Reads during the sweep return an all-zero entry.
        rtag_q <= bus.rtag;
        zero_q <= (state == INIT);
        byp_q  <= byp;
        v_q    <= valid[bus.raddr];
        if (byp) byp_ent <= '{V: bus.wV, BIA: bus.wBIA, BTA: bus.wBTA};
      end
    end
  end

  btb_ram #(.AW(IDX_W), .DW(TAG_W + TGT_W)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (bus.waddr),
    .wdata ({bus.wBIA, bus.wBTA}),
    .re    (bus.ren && (state == RUN)),
    .raddr (bus.raddr),
    .rdata (ram_rd)
  );

  always_comb begin
    v_o   = 1'b0;
    bia_o = '0;
    bta_o = '0;
    if (!zero_q) begin
      if (byp_q) begin
        v_o   = byp_ent.V;
        bia_o = byp_ent.BIA;
        bta_o = byp_ent.BTA;
      end else begin
        v_o   = v_q;
        bia_o = ram_rd[TGT_W +: TAG_W];
        bta_o = ram_rd[TGT_W-1:0];
      end
    end
  end

  assign bus.ready  = (state == RUN);
  assign bus.rvalid = rvalid_q;
  assign bus.V      = v_o;
  assign bus.BIA    = bia_o;
  assign bus.BTA    = bta_o;
  assign bus.hit    = v_o && (bia_o == rtag_q);
  assign dbg_state  = state;
endmodule

// File: tb/tb_btb_store.sv
// Directed bench for btb_store: table model with generation-based invalidation,
// per-cycle output compare and literal checks on the key scenarios.
module tb_btb_store;
  import btb_pkg::*;

  logic       clk;
  logic       rst;
  btb_state_t dbg_state;
  btb_store_if bus ();

  btb_store dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  bit armed = 0;

  // Clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: an entry is valid only if written in the current generation;
  // reset and flush start a new generation and a DEPTH-cycle blackout.
  int unsigned      rem = DEPTH;
  int unsigned      cur_gen = 0;
  int unsigned      ent_gen [DEPTH];
  bit               m_v     [DEPTH];
  bit               known   [DEPTH];
  logic [TAG_W-1:0] m_bia   [DEPTH];
  logic [TGT_W-1:0] m_bta   [DEPTH];
  logic             exp_rvalid = 0, exp_v = 0, exp_hit = 0, exp_known = 1;
  logic [TAG_W-1:0] exp_bia = '0;
  logic [TGT_W-1:0] exp_bta = '0;
  bit               sweeping;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem = DEPTH;
      cur_gen++;
      exp_rvalid = 0; exp_v = 0; exp_hit = 0; exp_known = 1;
      exp_bia = '0; exp_bta = '0;
    end else begin
      sweeping = (rem != 0);
      if (bus.ren) begin
        exp_rvalid = 1;
        if (sweeping) begin
          exp_v = 0; exp_bia = '0; exp_bta = '0; exp_known = 1;
        end else if (bus.wen && !bus.flush && bus.waddr == bus.raddr) begin
          exp_v = bus.wV; exp_bia = bus.wBIA; exp_bta = bus.wBTA; exp_known = 1;
        end else begin
          exp_v     = m_v[bus.raddr] && (ent_gen[bus.raddr] == cur_gen);
          exp_bia   = m_bia[bus.raddr];
          exp_bta   = m_bta[bus.raddr];
          exp_known = known[bus.raddr];
        end
        exp_hit = exp_v && (exp_bia == bus.rtag);
      end else begin
        exp_rvalid = 0;
      end
      if (bus.wen && !bus.flush && !sweeping) begin
        m_v[bus.waddr]     = bus.wV;
        m_bia[bus.waddr]   = bus.wBIA;
        m_bta[bus.waddr]   = bus.wBTA;
        known[bus.waddr]   = 1;
        ent_gen[bus.waddr] = cur_gen;
      end
      if (bus.flush) begin
        rem = DEPTH;
        cur_gen++;
      end else if (rem != 0) begin
        rem--;
      end
    end
  end

  // Scoreboard check
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("cyc_ready", 32'(bus.ready), 32'(rem == 0));
      chk("cyc_rvalid", 32'(bus.rvalid), 32'(exp_rvalid));
      chk("cyc_V", 32'(bus.V), 32'(exp_v));
      chk("cyc_hit", 32'(bus.hit), 32'(exp_hit));
      if (exp_known) begin
        chk("cyc_BIA", 32'(bus.BIA), 32'(exp_bia));
        chk("cyc_BTA", bus.BTA, exp_bta);
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush = 0; bus.wen = 0; bus.ren = 0;
    bus.waddr = '0; bus.wV = 0; bus.wBIA = '0; bus.wBTA = '0;
    bus.raddr = '0; bus.rtag = '0;
  endtask

  task automatic wr(input logic [IDX_W-1:0] a, input logic v,
                    input logic [TAG_W-1:0] t, input logic [TGT_W-1:0] d);
    bus.wen = 1; bus.waddr = a; bus.wV = v; bus.wBIA = t; bus.wBTA = d;
  endtask

  task automatic rd(input logic [IDX_W-1:0] a, input logic [TAG_W-1:0] t);
    bus.ren = 1; bus.raddr = a; bus.rtag = t;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!bus.ready && n < 20000) begin
      step();
      n++;
    end
    chk(nm, n, 8192);
  endtask

  initial begin
    int n;
    rst = 1;
    idle();
    #1 rst = 0;
    armed = 1;
    #1;
    chk("rst_ready", 32'(bus.ready), 0);
    chk("rst_V", 32'(bus.V), 0);
    chk("rst_BTA", bus.BTA, 0);
    repeat (3) step();
    rst = 1;
    wait_ready("init_sweep_len");

    rd(13'h1FFF, 8'h00); step();
    chk("empty_rvalid", 32'(bus.rvalid), 1);
    chk("empty_V", 32'(bus.V), 0);
    chk("empty_hit", 32'(bus.hit), 0);

    idle(); wr(13'h0042, 1, 8'hA5, 32'h8000_1000); step();
    idle(); rd(13'h0042, 8'hA5); step();
    chk("a5_rvalid", 32'(bus.rvalid), 1);
    chk("a5_V", 32'(bus.V), 1);
    chk("a5_BTA", bus.BTA, 32'h8000_1000);
    chk("a5_hit", 32'(bus.hit), 1);
    rd(13'h0042, 8'h5A); step();
    chk("5a_hit", 32'(bus.hit), 0);

    idle(); wr(13'h0100, 1, 8'h11, 32'h8000_2000); rd(13'h0100, 8'h11); step();
    chk("byp_BIA", 32'(bus.BIA), 32'h11);
    chk("byp_BTA", bus.BTA, 32'h8000_2000);
    chk("byp_hit", 32'(bus.hit), 1);

    idle(); wr(13'h0101, 1, 8'h22, 32'h8000_3000); rd(13'h0042, 8'hA5); step();
    chk("diff_BIA", 32'(bus.BIA), 32'hA5);
    idle(); rd(13'h0101, 8'h22); step();
    chk("diff_BTA", bus.BTA, 32'h8000_3000);

    idle(); wr(13'h0004, 0, 8'h33, 32'h0000_0044); step();
    idle(); rd(13'h0004, 8'h33); step();
    chk("inv_V", 32'(bus.V), 0);
    chk("inv_hit", 32'(bus.hit), 0);

    for (int i = 1; i <= 3; i++) begin
      idle(); wr(13'(i), 1, 8'(8'h10 * i), 32'h4000_0000 + 32'(i)); step();
    end
    for (int i = 1; i <= 3; i++) begin
      idle(); rd(13'(i), 8'(8'h10 * i)); step();
      chk("b2b_BTA", bus.BTA, 32'h4000_0000 + 32'(i));
      chk("b2b_hit", 32'(bus.hit), 1);
    end
    idle(); step();
    chk("hold_rvalid", 32'(bus.rvalid), 0);
    chk("hold_BTA", bus.BTA, 32'h4000_0003);

    wr(13'h0000, 1, 8'h0A, 32'h0000_0A00); step();
    idle(); wr(13'h1FFF, 1, 8'hFF, 32'h0000_FF00); step();
    idle(); rd(13'h0000, 8'h0A); step();
    chk("pre_flush_hit", 32'(bus.hit), 1);
    idle(); bus.flush = 1; wr(13'h0200, 1, 8'h66, 32'h6666_6666); step();
    chk("flush_ready_drop", 32'(bus.ready), 0);
    n = 0;
    while (!bus.ready && n < 20000) begin
      idle();
      if (n == 10) wr(13'h0000, 1, 8'h77, 32'h1234_5678);
      if (n == 20) rd(13'h1FFF, 8'hFF);
      step();
      n++;
      if (n == 21) begin
        chk("sweep_rd_rvalid", 32'(bus.rvalid), 1);
        chk("sweep_rd_V", 32'(bus.V), 0);
        chk("sweep_rd_BTA", bus.BTA, 0);
      end
    end
    chk("flush_sweep_len", n, 8192);
    idle(); rd(13'h0000, 8'h77); step();
    chk("drop_wr_V", 32'(bus.V), 0);
    chk("drop_wr_hit", 32'(bus.hit), 0);
    idle(); rd(13'h1FFF, 8'hFF); step();
    chk("flushed_V", 32'(bus.V), 0);

    idle(); wr(13'h0007, 1, 8'h70, 32'h7000_0007); step();
    idle(); rd(13'h0007, 8'h70); step();
    chk("pre_rst_BTA", bus.BTA, 32'h7000_0007);
    idle(); bus.flush = 1; step();
    idle(); repeat (100) step();
    rst = 0;
    #1;
    chk("mid_rst_V", 32'(bus.V), 0);
    chk("mid_rst_BIA", 32'(bus.BIA), 0);
    chk("mid_rst_BTA", bus.BTA, 0);
    chk("mid_rst_hit", 32'(bus.hit), 0);
    repeat (2) step();
    rst = 1;
    wait_ready("rst_sweep_len");
    idle(); rd(13'h0007, 8'h70); step();
    chk("post_rst_V", 32'(bus.V), 0);
    idle(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
